// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester ports and SRAM pad signals of the two-port SRAM arbiter
//
// Purpose: bundles both requester handshakes and the SRAM-side pins.
// Ports (as seen from the arbiter, modport slave):
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1   in   per-port request, direction, address, write data
//   done0/done1                                      out  one-cycle completion pulse to the served port
//   rdata                                            out  last read result, shared by both ports
//   SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N,
//   SRAM_LB_N, SRAM_UB_N                             out  SRAM address and active-low strobes
//   sram_dq_out, sram_dq_oe                          out  pad write data and pad drive enable
//   sram_dq_in                                       in   data sampled from the pads
// The master modport is the mirror image (requesters plus the SRAM model).
interface sram_arbiter_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
);
   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              done0;
   logic              done1;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] SRAM_ADDR;
   logic              SRAM_CE_N;
   logic              SRAM_OE_N;
   logic              SRAM_WE_N;
   logic              SRAM_LB_N;
   logic              SRAM_UB_N;
   logic [DATA_W-1:0] sram_dq_out;
   logic              sram_dq_oe;
   logic [DATA_W-1:0] sram_dq_in;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_dq_in,
      output done0, done1, rdata, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N,
             SRAM_LB_N, SRAM_UB_N, sram_dq_out, sram_dq_oe
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_dq_in,
      input  done0, done1, rdata, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N,
             SRAM_LB_N, SRAM_UB_N, sram_dq_out, sram_dq_oe
   );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin two-port arbiter driving an asynchronous SRAM
//
// Purpose: grants one of two requesters (port 0 = sprite fetch, port 1 = host)
// and runs a single SRAM read or write lasting WAIT_CYCLES clocks, followed by
// a one-cycle DONE phase that releases the strobes and pulses done to the
// served port. Every output comes straight from a flop.
// Ports:
//   clk    in  single clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    sram_arbiter_if.slave: requester handshakes and SRAM pad signals
module sram_arbiter #(
   parameter int ADDR_W      = 20,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   sram_arbiter_if.slave       bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic              last, last_nxt;     // port served most recently
   logic              gnt, gnt_nxt;       // port owning the access in flight
   logic              lat_we, lat_we_nxt;
   logic              pick;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [DATA_W-1:0] dq_out_q, dq_out_nxt;
   logic [DATA_W-1:0] rdata_q, rdata_nxt;
   logic              ce_n_q, ce_n_nxt;
   logic              oe_n_q, oe_n_nxt;
   logic              we_n_q, we_n_nxt;
   logic              bs_n_q, bs_n_nxt;   // LB_N and UB_N always move together
   logic              dq_oe_q, dq_oe_nxt;
   logic              done0_q, done0_nxt;
   logic              done1_q, done1_nxt;

   // A lone requester wins outright; on a tie the port not served last wins.
   assign pick = (bus.req0 && bus.req1) ? ~last : bus.req1;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      last_nxt   = last;
      gnt_nxt    = gnt;
      lat_we_nxt = lat_we;
      addr_nxt   = addr_q;
      dq_out_nxt = dq_out_q;
      rdata_nxt  = rdata_q;
      ce_n_nxt   = 1'b1;
      oe_n_nxt   = 1'b1;
      we_n_nxt   = 1'b1;
      bs_n_nxt   = 1'b1;
      dq_oe_nxt  = 1'b0;
      done0_nxt  = 1'b0;
      done1_nxt  = 1'b0;

      case (state)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               gnt_nxt    = pick;
               last_nxt   = pick;
               lat_we_nxt = pick ? bus.we1 : bus.we0;
               addr_nxt   = pick ? bus.addr1 : bus.addr0;
               if (lat_we_nxt) begin
                  dq_out_nxt = pick ? bus.wdata1 : bus.wdata0;
               end
               cnt_nxt    = CNT_LOAD;
               state_nxt  = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt == 4'd0) begin
               state_nxt = DONE;
               if (!lat_we) begin
                  rdata_nxt = bus.sram_dq_in;
               end
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Outputs are decoded from the state being entered so that the
      // registered strobes line up with the state they belong to.
      case (state_nxt)
         ACCESS: begin
            ce_n_nxt  = 1'b0;
            bs_n_nxt  = 1'b0;
            oe_n_nxt  = lat_we_nxt;
            we_n_nxt  = ~lat_we_nxt;
            dq_oe_nxt = lat_we_nxt;
         end
         DONE: begin
            // keep driving write data one more cycle for SRAM hold time
            dq_oe_nxt = lat_we_nxt;
            done0_nxt = ~gnt_nxt;
            done1_nxt = gnt_nxt;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         last     <= 1'b1;
         gnt      <= 1'b0;
         lat_we   <= 1'b0;
         addr_q   <= '0;
         dq_out_q <= '0;
         rdata_q  <= '0;
         ce_n_q   <= 1'b1;
         oe_n_q   <= 1'b1;
         we_n_q   <= 1'b1;
         bs_n_q   <= 1'b1;
         dq_oe_q  <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         last     <= last_nxt;
         gnt      <= gnt_nxt;
         lat_we   <= lat_we_nxt;
         addr_q   <= addr_nxt;
         dq_out_q <= dq_out_nxt;
         rdata_q  <= rdata_nxt;
         ce_n_q   <= ce_n_nxt;
         oe_n_q   <= oe_n_nxt;
         we_n_q   <= we_n_nxt;
         bs_n_q   <= bs_n_nxt;
         dq_oe_q  <= dq_oe_nxt;
         done0_q  <= done0_nxt;
         done1_q  <= done1_nxt;
      end
   end

   assign bus.done0       = done0_q;
   assign bus.done1       = done1_q;
   assign bus.rdata       = rdata_q;
   assign bus.SRAM_ADDR   = addr_q;
   assign bus.SRAM_CE_N   = ce_n_q;
   assign bus.SRAM_OE_N   = oe_n_q;
   assign bus.SRAM_WE_N   = we_n_q;
   assign bus.SRAM_LB_N   = bs_n_q;
   assign bus.SRAM_UB_N   = bs_n_q;
   assign bus.sram_dq_out = dq_out_q;
   assign bus.sram_dq_oe  = dq_oe_q;

endmodule
